nexys_sevseg_scan: RTL and testbench

Parametrised, double-buffered scanner for the Nexys 7-segment display bank. It time-multiplexes DIGITS hex digits onto shared active-low cathodes and per-digit active-low anodes. It adds per-digit blanking, per-digit decimal points, a frame-sync pulse and glitch-free snapshot updates. It sits between any lab DUT (adder, ALU, CPU) and the board pins, replacing ad-hoc per-lab scan logic.

---
 rtl/nexys_disp_pkg.sv | 28 ++
 rtl/sevseg_decoder.sv | 15 +
 rtl/nexys_sevseg_scan.sv | 101 ++++++++++
 tb/tb_nexys_sevseg_scan.sv | 136 +++++++++++++
 4 files changed

// File: rtl/nexys_disp_pkg.sv
// nexys_disp_pkg: shared 7-segment constants and hex-to-cathode decode table.
package nexys_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Cathode order {CA..CG}, active-low
    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0:    hex2seg = 7'b0000001;
            4'h1:    hex2seg = 7'b1001111;
            4'h2:    hex2seg = 7'b0010010;
            4'h3:    hex2seg = 7'b0000110;
            4'h4:    hex2seg = 7'b1001100;
            4'h5:    hex2seg = 7'b0100100;
            4'h6:    hex2seg = 7'b0100000;
            4'h7:    hex2seg = 7'b0001111;
            4'h8:    hex2seg = 7'b0000000;
            4'h9:    hex2seg = 7'b0000100;
            4'hA:    hex2seg = 7'b0001000;
            4'hB:    hex2seg = 7'b1100000;
            4'hC:    hex2seg = 7'b0110001;
            4'hD:    hex2seg = 7'b1000010;
            4'hE:    hex2seg = 7'b0110000;
            default: hex2seg = 7'b0111000;
        endcase
    endfunction

endpackage

// File: rtl/sevseg_decoder.sv
// sevseg_decoder: one digit's cathode pattern and DP level, blanked when disabled.
module sevseg_decoder
    import nexys_disp_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       dp_i,
    input  logic       en_i,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    assign seg_o = en_i ? hex2seg(hex_i) : SEG_BLANK;
    assign dp_o  = ~(en_i & dp_i);

endmodule

// File: rtl/nexys_sevseg_scan.sv
// nexys_sevseg_scan: double-buffered multiplexed scanner for the Nexys 7-segment bank.
// Define SEVSEG_DIM_EN to add brightness_i and PWM dimming of the active anode.
module nexys_sevseg_scan
    import nexys_disp_pkg::*;
#(
    parameter int DIGITS  = 8,
    parameter int REFRESH = 1000
) (
    input  logic                  CLK100,
    input  logic                  resetn,
    input  logic [4*DIGITS-1:0]   hex_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     en_i,
    input  logic                  update_i,
`ifdef SEVSEG_DIM_EN
    input  logic [3:0]            brightness_i,
`endif
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int CNT_W = $clog2(REFRESH);
    localparam int IDX_W = $clog2(DIGITS);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d, nidx;
    logic [4*DIGITS-1:0] sh_hex_q, sh_hex_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, sh_en_q, sh_en_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d, dec_seg;
    logic                dp_q, dp_d, dec_dp, frame_q, frame_d, boundary;

    // Decode the digit being entered so anode and cathodes load on the same edge
    sevseg_decoder u_dec (
        .hex_i (sh_hex_q[{nidx, 2'b00} +: 4]),
        .dp_i  (sh_dp_q[nidx]),
        .en_i  (sh_en_q[nidx]),
        .seg_o (dec_seg),
        .dp_o  (dec_dp)
    );

    always_comb begin
        boundary = cnt_q == CNT_W'(REFRESH - 1);
        nidx     = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        cnt_d    = boundary ? '0 : cnt_q + 1'b1;
        idx_d    = boundary ? nidx : idx_q;
        sh_hex_d = update_i ? hex_i : sh_hex_q;
        sh_dp_d  = update_i ? dp_i : sh_dp_q;
        sh_en_d  = update_i ? en_i : sh_en_q;
        an_d     = boundary ? (sh_en_q[nidx] ? ~(DIGITS'(1) << nidx) : '1) : an_q;
        seg_d    = boundary ? dec_seg : seg_q;
        dp_d     = boundary ? dec_dp : dp_q;
        frame_d  = boundary && (nidx == '0);
    end

    always_ff @(posedge CLK100 or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            idx_q    <= IDX_W'(DIGITS - 1);
            sh_hex_q <= '0;
            sh_dp_q  <= '0;
            sh_en_q  <= '0;
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_hex_q <= sh_hex_d;
            sh_dp_q  <= sh_dp_d;
            sh_en_q  <= sh_en_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            frame_q  <= frame_d;
        end
    end

`ifdef SEVSEG_DIM_EN
    logic [3:0] duty_q, duty_d;

    assign duty_d = duty_q + 4'd1;

    always_ff @(posedge CLK100 or negedge resetn) begin
        if (!resetn) duty_q <= '0;
        else         duty_q <= duty_d;
    end

    assign an_o = an_q | {DIGITS{duty_q >= brightness_i}};
`else
    assign an_o = an_q;
`endif

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_nexys_sevseg_scan.sv
// tb_nexys_sevseg_scan: directed checks of scan order, decode, blanking, DP, snapshot timing and reset.
module tb_nexys_sevseg_scan;

    logic        CLK100 = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] hex_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  en_i = '0;
    logic        update_i = 1'b0;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;
`ifdef SEVSEG_DIM_EN
    logic [3:0]  brightness_i = 4'hF;
`endif

    int n_pass = 0;
    int n_total = 0;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    nexys_sevseg_scan #(.DIGITS(4), .REFRESH(4)) dut (
        .CLK100   (CLK100),
        .resetn   (resetn),
        .hex_i    (hex_i),
        .dp_i     (dp_i),
        .en_i     (en_i),
        .update_i (update_i),
`ifdef SEVSEG_DIM_EN
        .brightness_i (brightness_i),
`endif
        .seg_o    (seg_o),
        .dp_o     (dp_o),
        .an_o     (an_o),
        .frame_o  (frame_o)
    );

    always #5 CLK100 = ~CLK100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK100);
        #1;
    endtask

    task automatic upd(input logic [15:0] h, input logic [3:0] d, input logic [3:0] e);
        hex_i = h; dp_i = d; en_i = e; update_i = 1'b1;
        cyc(1);
        update_i = 1'b0;
    endtask

    task automatic slot(input string tag, input logic [3:0] an, input logic [6:0] seg,
                        input logic dp, input logic fr);
        chk({tag, "_an"}, 32'(an_o), 32'(an));
        chk({tag, "_seg"}, 32'(seg_o), 32'(seg));
        chk({tag, "_dp"}, 32'(dp_o), 32'(dp));
        chk({tag, "_frame"}, 32'(frame_o), 32'(fr));
    endtask

    initial begin
        cyc(3);
        slot("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        resetn = 1'b1;
        upd(16'h1234, 4'h0, 4'hF);
        cyc(2);
        slot("pre_first", 4'hF, 7'h7F, 1'b1, 1'b0);
        cyc(1);
        slot("d0_first", 4'b1110, 7'b1001100, 1'b1, 1'b1);
        cyc(1);
        slot("d0_mid", 4'b1110, 7'b1001100, 1'b1, 1'b0);
        cyc(3);
        slot("d1", 4'b1101, 7'b0000110, 1'b1, 1'b0);
        cyc(4);
        slot("d2", 4'b1011, 7'b0010010, 1'b1, 1'b0);
        cyc(4);
        slot("d3", 4'b0111, 7'b1001111, 1'b1, 1'b0);
        cyc(4);
        slot("d0_wrap", 4'b1110, 7'b1001100, 1'b1, 1'b1);
        for (int v = 0; v < 16; v++) begin
            upd(16'(v), 4'h0, 4'hF);
            cyc(15);
            chk($sformatf("hex%0h_seg", v), 32'(seg_o), 32'(seg_tab[v]));
            chk($sformatf("hex%0h_an", v), 32'(an_o), 32'(4'b1110));
        end
        upd(16'h1234, 4'b0001, 4'hF);
        cyc(3);
        slot("dp_d1", 4'b1101, 7'b0000110, 1'b1, 1'b0);
        cyc(12);
        slot("dp_d0", 4'b1110, 7'b1001100, 1'b0, 1'b1);
        cyc(4);
        chk("dp_d1b", 32'(dp_o), 32'(1'b1));
        upd(16'h1234, 4'h0, 4'b0101);
        cyc(3);
        slot("en_d2", 4'b1011, 7'b0010010, 1'b1, 1'b0);
        cyc(3);
        chk("en_d2_end", 32'(an_o), 32'(4'b1011));
        cyc(1);
        slot("en_d3_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
        cyc(3);
        chk("en_d3_end", 32'(an_o), 32'(4'hF));
        cyc(1);
        slot("en_d0", 4'b1110, 7'b1001100, 1'b1, 1'b1);
        cyc(4);
        slot("en_d1_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
        cyc(4);
        chk("en_d2_again", 32'(an_o), 32'(4'b1011));
        cyc(15);
        upd(16'hFFFF, 4'h0, 4'hF);
        slot("coinc_d2_old", 4'b1011, 7'b0010010, 1'b1, 1'b0);
        cyc(4);
        slot("coinc_d3_new", 4'b0111, 7'b0111000, 1'b1, 1'b0);
        cyc(2);
        resetn = 1'b0;
        #1;
        slot("async_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
        #1;
        resetn = 1'b1;
        upd(16'h1234, 4'h0, 4'hF);
        cyc(2);
        slot("rst_pre", 4'hF, 7'h7F, 1'b1, 1'b0);
        cyc(1);
        slot("rst_d0", 4'b1110, 7'b1001100, 1'b1, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
